pipe_ctrl_unit: RTL and testbench

//  Parametrised stall/flush controller for an NSTAGE in-order pipeline (default PreIF,IF,ID,EXE,MEM,MEM2,WB).

---
 rtl/pipe_ctrl_unit.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_unit
//  Description : Stall/flush controller for an NSTAGE in-order pipeline.
//                Produces per-stage write enables, flushes and side-effect
//                write disables from exception, branch, hazard, mul/div,
//                cache and TLB events. Holds a deferred branch redirect,
//                a multi-cycle exception flush counter and a stall watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int NSTAGE      = 7,
    parameter int HAZ_STAGES  = 3,
    parameter int MD_STAGE    = 3,
    parameter int FE_STAGES   = 3,
    parameter int REDIR_DEPTH = 1,
    parameter int DISWR_BASE  = 4,
    parameter int FLUSH_HOLD  = 1,
    parameter int CNT_W       = 8,
    parameter int WDOG_LIMIT  = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_exception,
    input  logic                  branch_failed,
    input  logic [HAZ_STAGES-1:0] dh_stall,
    input  logic                  exe_flush_dh,
    input  logic                  muldiv_busy,
    input  logic                  icache_busy,
    input  logic                  dcache_busy,
    input  logic                  i_tlb_stall,
    input  logic                  d_tlb_stall,
    output logic [NSTAGE-1:0]     stage_wr,
    output logic [NSTAGE-1:0]     stage_flush,
    output logic [NSTAGE-1:0]     stage_diswr,
    output logic                  icache_flush,
    output logic                  dcache_flush,
    output logic                  redirect_pending,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  wdog_timeout
);

    // Hold counter only needs to represent 0..FLUSH_HOLD-1.
    localparam int                  c_HOLD_W    = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(FLUSH_HOLD - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_WDOG      = CNT_W'(WDOG_LIMIT);

    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_redirect_pending;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_exc;
    logic                w_busy;
    logic                w_redir;
    logic [NSTAGE-1:0]   w_norm_wr;
    logic [NSTAGE-1:0]   w_norm_flush;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_pending_nxt;
    logic [CNT_W-1:0]    w_stall_nxt;

    // An exception stays active while the hold counter drains after the pulse.
    assign w_exc   = flush_exception | (r_hold_cnt != '0);
    assign w_busy  = icache_busy | dcache_busy | d_tlb_stall;
    assign w_redir = branch_failed | r_redirect_pending;

    // Quiet-pipeline controls: hazard stalls, mul/div freeze and hazard bubble.
    always_comb begin
        w_norm_wr    = '1;
        w_norm_flush = '0;
        for (int i = 0; i < HAZ_STAGES; i++) begin
            w_norm_wr[i] = ~(dh_stall[i] | muldiv_busy);
        end
        for (int i = 0; i < NSTAGE; i++) begin
            if (i <= MD_STAGE) begin
                w_norm_wr[i] = w_norm_wr[i] & ~muldiv_busy;
            end
            if (i == HAZ_STAGES) begin
                w_norm_flush[i] = exe_flush_dh;
            end
        end
    end

    // Priority resolution: exception, cache busy, I-TLB stall, redirect, normal.
    always_comb begin
        stage_wr      = w_norm_wr;
        stage_flush   = w_norm_flush;
        stage_diswr   = '0;
        icache_flush  = 1'b0;
        dcache_flush  = 1'b0;
        w_pending_nxt = r_redirect_pending;
        w_hold_nxt    = r_hold_cnt;

        if (w_exc) begin
            stage_wr     = '1;
            stage_flush  = '0;
            for (int i = 1; i < NSTAGE - 1; i++) begin
                stage_flush[i] = 1'b1;
            end
            icache_flush  = 1'b1;
            dcache_flush  = 1'b1;
            w_pending_nxt = 1'b0;
            w_hold_nxt    = flush_exception ? c_HOLD_LOAD : (r_hold_cnt - 1'b1);
        end else if (w_busy) begin
            stage_wr    = '0;
            stage_flush = '0;
            for (int i = 0; i < NSTAGE; i++) begin
                if (i >= DISWR_BASE) begin
                    stage_diswr[i] = 1'b1;
                end
            end
            w_pending_nxt = r_redirect_pending | branch_failed;
        end else if (i_tlb_stall) begin
            // Front end frozen; the back end keeps its normal behaviour.
            for (int i = 0; i < NSTAGE; i++) begin
                if (i < FE_STAGES) begin
                    stage_wr[i] = 1'b0;
                end
            end
            w_pending_nxt = r_redirect_pending | branch_failed;
        end else if (w_redir) begin
            stage_wr    = '1;
            stage_flush = '0;
            for (int i = 1; i < NSTAGE; i++) begin
                if (i <= MD_STAGE && muldiv_busy) begin
                    stage_wr[i] = 1'b0;
                end
                if (i <= REDIR_DEPTH) begin
                    stage_flush[i] = 1'b1;
                end
            end
            icache_flush  = 1'b1;
            w_pending_nxt = 1'b0;
        end
    end

    // Count consecutive PC-stall cycles outside exceptions, saturating.
    always_comb begin
        w_stall_nxt = '0;
        if (!stage_wr[0] && !w_exc) begin
            w_stall_nxt = (r_stall_cnt == c_CNT_MAX) ? r_stall_cnt : (r_stall_cnt + 1'b1);
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt         <= '0;
            r_redirect_pending <= 1'b0;
            r_stall_cnt        <= '0;
        end else begin
            r_hold_cnt         <= w_hold_nxt;
            r_redirect_pending <= w_pending_nxt;
            r_stall_cnt        <= w_stall_nxt;
        end
    end

    assign redirect_pending = r_redirect_pending;
    assign stall_cnt        = r_stall_cnt;
    assign wdog_timeout     = (r_stall_cnt >= c_WDOG);

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl_unit
//  Description : Self-checking bench for pipe_ctrl_unit: single-cycle vector
//                table, directed multi-cycle sequences and randomized traffic
//                compared against a rule-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    localparam int NS    = 7;
    localparam int HAZ   = 3;
    localparam int MDS   = 3;
    localparam int FES   = 3;
    localparam int RDD   = 1;
    localparam int DWB   = 4;
    localparam int FH    = 3;
    localparam int CW    = 8;
    localparam int WDL   = 200;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_exception, branch_failed, exe_flush_dh, muldiv_busy;
    logic          icache_busy, dcache_busy, i_tlb_stall, d_tlb_stall;
    logic [HAZ-1:0] dh_stall;
    logic [NS-1:0] stage_wr, stage_flush, stage_diswr;
    logic          icache_flush, dcache_flush, redirect_pending, wdog_timeout;
    logic [CW-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_hold, m_pend, m_cnt;
    int n_hold, n_pend, n_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(
        .NSTAGE(NS), .HAZ_STAGES(HAZ), .MD_STAGE(MDS), .FE_STAGES(FES),
        .REDIR_DEPTH(RDD), .DISWR_BASE(DWB), .FLUSH_HOLD(FH), .CNT_W(CW),
        .WDOG_LIMIT(WDL)
    ) dut (
        .clk(clk), .rst(rst),
        .flush_exception(flush_exception), .branch_failed(branch_failed),
        .dh_stall(dh_stall), .exe_flush_dh(exe_flush_dh), .muldiv_busy(muldiv_busy),
        .icache_busy(icache_busy), .dcache_busy(dcache_busy),
        .i_tlb_stall(i_tlb_stall), .d_tlb_stall(d_tlb_stall),
        .stage_wr(stage_wr), .stage_flush(stage_flush), .stage_diswr(stage_diswr),
        .icache_flush(icache_flush), .dcache_flush(dcache_flush),
        .redirect_pending(redirect_pending), .stall_cnt(stall_cnt),
        .wdog_timeout(wdog_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit fe, input bit bf, input bit [2:0] dh, input bit exfl,
                          input bit md, input bit ib, input bit db, input bit it, input bit dt);
        flush_exception = fe; branch_failed = bf; dh_stall = dh; exe_flush_dh = exfl;
        muldiv_busy = md; icache_busy = ib; dcache_busy = db; i_tlb_stall = it; d_tlb_stall = dt;
    endtask

    // Rule-level model: pick the winning event class, then derive each stage.
    task automatic model_cmp();
        bit exc, busy, redir;
        int rule;
        logic [NS-1:0] e_wr, e_fl, e_dw;
        bit nwr;
        exc   = flush_exception || (m_hold > 0);
        busy  = icache_busy || dcache_busy || d_tlb_stall;
        redir = branch_failed || (m_pend != 0);
        rule  = exc ? 1 : busy ? 2 : i_tlb_stall ? 3 : redir ? 4 : 5;
        for (int s = 0; s < NS; s++) begin
            nwr = !(((s < HAZ) && dh_stall[s]) || ((s <= MDS) && muldiv_busy));
            e_dw[s] = 1'b0;
            case (rule)
                1: begin e_wr[s] = 1'b1; e_fl[s] = (s >= 1) && (s <= NS - 2); end
                2: begin e_wr[s] = 1'b0; e_fl[s] = 1'b0; e_dw[s] = (s >= DWB); end
                3: begin e_wr[s] = (s < FES) ? 1'b0 : nwr; e_fl[s] = (s == HAZ) && exe_flush_dh; end
                4: begin e_wr[s] = (s == 0) || !((s <= MDS) && muldiv_busy); e_fl[s] = (s >= 1) && (s <= RDD); end
                default: begin e_wr[s] = nwr; e_fl[s] = (s == HAZ) && exe_flush_dh; end
            endcase
        end
        chk("mdl_stage_wr", 32'(stage_wr), 32'(e_wr));
        chk("mdl_stage_flush", 32'(stage_flush), 32'(e_fl));
        chk("mdl_stage_diswr", 32'(stage_diswr), 32'(e_dw));
        chk("mdl_icache_flush", 32'(icache_flush), 32'(rule == 1 || rule == 4));
        chk("mdl_dcache_flush", 32'(dcache_flush), 32'(rule == 1));
        chk("mdl_redirect_pending", 32'(redirect_pending), 32'(m_pend));
        chk("mdl_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("mdl_wdog", 32'(wdog_timeout), 32'(m_cnt >= WDL));
        n_pend = (rule == 1 || rule == 4) ? 0 : (rule == 5) ? m_pend : ((m_pend != 0 || branch_failed) ? 1 : 0);
        n_hold = (rule == 1) ? (flush_exception ? FH - 1 : m_hold - 1) : m_hold;
        n_cnt  = (!e_wr[0] && !exc) ? ((m_cnt < CMAX) ? m_cnt + 1 : CMAX) : 0;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        model_cmp();
        @(posedge clk);
        if (rst) begin m_hold = 0; m_pend = 0; m_cnt = 0; end
        else begin m_hold = n_hold; m_pend = n_pend; m_cnt = n_cnt; end
        #1;
    endtask

    task automatic tick();
        half(); fin();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        m_hold = 0; m_pend = 0; m_cnt = 0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit fe, bf; bit [2:0] dh; bit exfl, md, ib, db, it, dt;
        logic [NS-1:0] wr, fl, dw;
        bit icf, dcf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(bit fe, bit bf, bit [2:0] dh, bit exfl, bit md, bit ib, bit db,
                                 bit it, bit dt, logic [NS-1:0] wr, logic [NS-1:0] fl,
                                 logic [NS-1:0] dw, bit icf, bit dcf);
        vec_t v;
        v.fe = fe; v.bf = bf; v.dh = dh; v.exfl = exfl; v.md = md; v.ib = ib; v.db = db;
        v.it = it; v.dt = dt; v.wr = wr; v.fl = fl; v.dw = dw; v.icf = icf; v.dcf = dcf;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        set_in(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        m_hold = 0; m_pend = 0; m_cnt = 0;

        // reset state
        half();
        chk("rst_stage_wr", 32'(stage_wr), 32'h7f);
        chk("rst_stage_flush", 32'(stage_flush), 32'h0);
        chk("rst_stage_diswr", 32'(stage_diswr), 32'h0);
        chk("rst_pending", 32'(redirect_pending), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        fin();
        rst = 1'b0;

        //           fe bf dh     ex md ib db it dt  wr        flush     diswr    icf dcf
        vecs.push_back(mkv(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 7'h7f, 7'h00, 7'h00, 0, 0));
        vecs.push_back(mkv(0, 0, 3'b111, 1, 0, 0, 0, 0, 0, 7'h78, 7'h08, 7'h00, 0, 0));
        vecs.push_back(mkv(0, 0, 3'b000, 0, 0, 0, 1, 0, 0, 7'h00, 7'h00, 7'h70, 0, 0));
        vecs.push_back(mkv(0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 7'h78, 7'h00, 7'h00, 0, 0));
        vecs.push_back(mkv(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 7'h7f, 7'h02, 7'h00, 1, 0));
        vecs.push_back(mkv(0, 1, 3'b101, 0, 1, 0, 0, 0, 0, 7'h71, 7'h02, 7'h00, 1, 0));
        vecs.push_back(mkv(0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 7'h70, 7'h00, 7'h00, 0, 0));
        vecs.push_back(mkv(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 7'h7f, 7'h3e, 7'h00, 1, 1));
        vecs.push_back(mkv(1, 1, 3'b000, 0, 0, 1, 0, 0, 0, 7'h7f, 7'h3e, 7'h00, 1, 1));
        vecs.push_back(mkv(0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 7'h7d, 7'h00, 7'h00, 0, 0));
        vecs.push_back(mkv(0, 0, 3'b001, 1, 0, 0, 0, 1, 0, 7'h78, 7'h08, 7'h00, 0, 0));
        vecs.push_back(mkv(0, 1, 3'b000, 0, 0, 0, 0, 0, 1, 7'h00, 7'h00, 7'h70, 0, 0));
        vecs.push_back(mkv(0, 0, 3'b000, 0, 1, 1, 0, 1, 0, 7'h00, 7'h00, 7'h70, 0, 0));

        foreach (vecs[k]) begin
            do_reset();
            set_in(vecs[k].fe, vecs[k].bf, vecs[k].dh, vecs[k].exfl, vecs[k].md,
                   vecs[k].ib, vecs[k].db, vecs[k].it, vecs[k].dt);
            half();
            chk($sformatf("vec%0d_wr", k), 32'(stage_wr), 32'(vecs[k].wr));
            chk($sformatf("vec%0d_flush", k), 32'(stage_flush), 32'(vecs[k].fl));
            chk($sformatf("vec%0d_diswr", k), 32'(stage_diswr), 32'(vecs[k].dw));
            chk($sformatf("vec%0d_icf", k), 32'(icache_flush), 32'(vecs[k].icf));
            chk($sformatf("vec%0d_dcf", k), 32'(dcache_flush), 32'(vecs[k].dcf));
            fin();
        end

        // T1: redirect deferred behind a D$ stall
        do_reset();
        set_in(0, 1, 3'b000, 0, 0, 0, 1, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            set_in(0, 0, 3'b000, 0, 0, 0, 1, 0, 0);
            half();
            chk("t1_pending_busy", 32'(redirect_pending), 32'h1);
            chk("t1_no_icf_busy", 32'(icache_flush), 32'h0);
            fin();
        end
        set_in(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        half();
        chk("t1_pending_apply", 32'(redirect_pending), 32'h1);
        chk("t1_flush1", 32'(stage_flush[1]), 32'h1);
        chk("t1_icf", 32'(icache_flush), 32'h1);
        fin();
        half();
        chk("t1_pending_clear", 32'(redirect_pending), 32'h0);
        fin();

        // T2: exception flush held FLUSH_HOLD cycles
        do_reset();
        set_in(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < FH; c++) begin
            half();
            chk("t2_flush_hold", 32'(stage_flush), 32'h3e);
            chk("t2_dcf_hold", 32'(dcache_flush), 32'h1);
            fin();
            set_in(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        end
        half();
        chk("t2_flush_end", 32'(stage_flush), 32'h0);
        chk("t2_dcf_end", 32'(dcache_flush), 32'h0);
        fin();

        // T4: long mul/div stall drives the watchdog
        do_reset();
        set_in(0, 0, 3'b000, 0, 1, 0, 0, 0, 0);
        for (int c = 0; c < 250; c++) begin
            half();
            if (c == WDL - 1) chk("t4_wdog_low", 32'(wdog_timeout), 32'h0);
            if (c == WDL)     chk("t4_wdog_high", 32'(wdog_timeout), 32'h1);
            fin();
        end
        set_in(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        half();
        chk("t4_cnt_250", 32'(stall_cnt), 32'd250);
        fin();
        half();
        chk("t4_cnt_zero", 32'(stall_cnt), 32'd0);
        chk("t4_wdog_drop", 32'(wdog_timeout), 32'h0);
        fin();

        // T4b: saturation of the stall counter
        set_in(0, 0, 3'b000, 0, 1, 0, 0, 0, 0);
        for (int c = 0; c < CMAX + 5; c++) tick();
        half();
        chk("t4_cnt_sat", 32'(stall_cnt), 32'(CMAX));
        fin();

        // T5: exception wins over redirect and cache busy
        do_reset();
        set_in(1, 1, 3'b000, 0, 0, 1, 0, 0, 0);
        tick();
        set_in(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        half();
        chk("t5_pending", 32'(redirect_pending), 32'h0);
        fin();

        // T6: I-TLB stall latches redirect, async reset discards it
        do_reset();
        set_in(0, 1, 3'b000, 0, 0, 0, 0, 1, 0);
        half();
        chk("t6_wr_fe", 32'(stage_wr[2:0]), 32'h0);
        fin();
        chk("t6_pending_set", 32'(redirect_pending), 32'h1);
        chk("t6_cnt_one", 32'(stall_cnt), 32'h1);
        set_in(0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        #1;
        m_hold = 0; m_pend = 0; m_cnt = 0;
        chk("t6_rst_pending", 32'(redirect_pending), 32'h0);
        chk("t6_rst_cnt", 32'(stall_cnt), 32'h0);
        tick();
        rst = 1'b0;

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                set_in($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 12,
                       3'($urandom_range(0, 7)), $urandom_range(0, 99) < 10,
                       $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                       $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
                       $urandom_range(0, 99) < 5);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
